// File: rtl/hysteresis_filter_pkg.sv
// rtl/hysteresis_filter_pkg.sv - shared frame constants, FSM state type and edge decision helper
package hysteresis_filter_pkg;

  localparam int WIDTH  = 720;
  localparam int HEIGHT = 540;

  localparam logic [7:0] HIGH_TH = 8'd48;
  localparam logic [7:0] LOW_TH  = 8'd12;

  typedef logic [7:0] pix_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } hyst_state_e;

  // Single-pass hysteresis: strong pixels pass, weak pixels pass only when a
  // strong pixel touches them; border handling is left to the caller.
  function automatic logic edge_decision(input pix_t p, input logic [7:0][7:0] n,
                                         input pix_t hi, input pix_t lo);
    logic strong_nbr;
    strong_nbr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (n[i] > hi) strong_nbr = 1'b1;
    end
    return (p > hi) | ((p > lo) & strong_nbr);
  endfunction

endpackage

// File: rtl/hysteresis_filter_if.sv
// rtl/hysteresis_filter_if.sv - upstream pop / downstream push FIFO handshake bundle
interface hysteresis_filter_if;
  import hysteresis_filter_pkg::*;

  logic in_rd_en;
  logic in_empty;
  pix_t in_dout;
  logic out_wr_en;
  logic out_full;
  pix_t out_din;

  // Filter side: pops the magnitude FIFO, pushes the edge FIFO.
  modport master (
    output in_rd_en,
    input  in_empty,
    input  in_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  // FIFO side.
  modport slave (
    input  in_rd_en,
    output in_empty,
    output in_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );

endinterface

// File: rtl/hysteresis_filter_line_buffer.sv
// rtl/hysteresis_filter_line_buffer.sv - two-row byte line buffer, read-before-write at one pointer
module hyst_line_buffer
  import hysteresis_filter_pkg::*;
#(
  parameter int DEPTH = 720,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] ptr_i,
  input  pix_t          px_i,
  output pix_t          row0_o,
  output pix_t          row1_o
);

  // Both rows share one word so a single write shifts the column upward.
  logic [15:0] mem_q [DEPTH];

  assign {row0_o, row1_o} = mem_q[ptr_i];

  // Older row takes the younger row's byte, younger row takes the new pixel.
  always_ff @(posedge clock) begin
    if (we_i) mem_q[ptr_i] <= {row1_o, px_i};
  end

endmodule

// File: rtl/hysteresis_filter.sv
// rtl/hysteresis_filter.sv - streaming 3x3 hysteresis threshold between two FWFT FIFOs
module hysteresis_filter
  import hysteresis_filter_pkg::hyst_state_e, hysteresis_filter_pkg::FILL,
         hysteresis_filter_pkg::RUN, hysteresis_filter_pkg::FLUSH,
         hysteresis_filter_pkg::edge_decision;
#(
  parameter int         WIDTH   = hysteresis_filter_pkg::WIDTH,
  parameter int         HEIGHT  = hysteresis_filter_pkg::HEIGHT,
  parameter logic [7:0] HIGH_TH = hysteresis_filter_pkg::HIGH_TH,
  parameter logic [7:0] LOW_TH  = hysteresis_filter_pkg::LOW_TH
) (
  input  logic                 clock,
  input  logic                 reset,
  hysteresis_filter_if.master  fifo_if
);

  localparam int PIX   = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(PIX + 1);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  localparam logic [CNT_W-1:0] FILL_CNT = CNT_W'(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIX);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  hyst_state_e      state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [ROW_W-1:0] orow_q, orow_d;
  logic [COL_W-1:0] ocol_q, ocol_d;
  logic [COL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       win_q [3][3];
  logic [7:0]       win_d [3][3];
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;

  logic             adv, step, emit, frame_done;
  logic [7:0]       new_px, lb_row0, lb_row1;
  logic [7:0][7:0]  nbr;
  logic             is_border, edge_hit;

  // A step needs room in the output register; FLUSH feeds zeros instead of FIFO data.
  assign adv        = ~out_valid_q | ~fifo_if.out_full;
  assign step       = adv & ((state_q == FLUSH) | ~fifo_if.in_empty);
  assign emit       = step & (state_q != FILL);
  assign new_px     = (state_q == FLUSH) ? 8'h00 : fifo_if.in_dout;
  assign frame_done = emit & (orow_q == ROW_LAST) & (ocol_q == COL_LAST);

  assign fifo_if.in_rd_en  = step & (state_q != FLUSH) & ~reset;
  assign fifo_if.out_wr_en = out_valid_q & ~fifo_if.out_full;
  assign fifo_if.out_din   = out_data_q;

  hyst_line_buffer #(
    .DEPTH (WIDTH),
    .AW    (COL_W)
  ) u_line_buffer (
    .clock  (clock),
    .we_i   (step),
    .ptr_i  (ptr_q),
    .px_i   (new_px),
    .row0_o (lb_row0),
    .row1_o (lb_row1)
  );

  // Next window: shift columns left, right column is {two rows up, one row up, new pixel}.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) win_d[r][c] = win_q[r][c];
    end
    if (step) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_row0;
      win_d[1][2] = lb_row1;
      win_d[2][2] = new_px;
    end
  end

  // The decision looks at the post-shift window, whose centre is the output pixel.
  assign nbr = {win_d[0][0], win_d[0][1], win_d[0][2],
                win_d[1][0],              win_d[1][2],
                win_d[2][0], win_d[2][1], win_d[2][2]};

  assign is_border = (orow_q == '0) | (orow_q == ROW_LAST) |
                     (ocol_q == '0) | (ocol_q == COL_LAST);
  assign edge_hit  = ~is_border & edge_decision(win_d[1][1], nbr, HIGH_TH, LOW_TH);

  // FSM, counters and output register next-state.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q & ~fifo_if.out_wr_en;
    out_data_d  = out_data_q;
    if (step) begin
      ptr_d = (ptr_q == COL_LAST) ? '0 : ptr_q + 1'b1;
      if (state_q != FLUSH) in_cnt_d = in_cnt_q + 1'b1;
      if (emit) begin
        out_valid_d = 1'b1;
        out_data_d  = edge_hit ? 8'hFF : 8'h00;
        if (ocol_q == COL_LAST) begin
          ocol_d = '0;
          orow_d = orow_q + 1'b1;
        end else begin
          ocol_d = ocol_q + 1'b1;
        end
      end
      case (state_q)
        FILL:  if (in_cnt_d == FILL_CNT) state_d = RUN;
        RUN:   if (in_cnt_d == LAST_CNT) state_d = FLUSH;
        FLUSH: begin
          if (frame_done) begin
            state_d  = FILL;
            in_cnt_d = '0;
            orow_d   = '0;
            ocol_d   = '0;
            ptr_d    = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State registers; line-buffer contents are not cleared since borders mask stale data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      in_cnt_q    <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win_q[r][c] <= win_d[r][c];
      end
    end
  end

endmodule

// File: tb/tb_hysteresis_filter.sv
// tb/tb_hysteresis_filter.sv - randomized self-checking bench for hysteresis_filter
module tb_hysteresis_filter;
  import hysteresis_filter_pkg::*;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic clock = 1'b0;
  logic reset;

  hysteresis_filter_if bus ();

  hysteresis_filter #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .HIGH_TH (8'd48),
    .LOW_TH  (8'd12)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .fifo_if (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] in_q  [$];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] clean_q [$];
  logic [7:0] frame [N];

  int bubble_pct = 0;
  int full_pct   = 0;
  int rd_viol    = 0;
  int wr_viol    = 0;
  int vectors    = 0;
  int miscompares = 0;

  // FIFO models: inputs change on the falling edge, transfers decided just after.
  initial begin
    bus.in_empty = 1'b1;
    bus.in_dout  = 8'h00;
    bus.out_full = 1'b0;
    forever begin
      @(negedge clock);
      bus.in_empty = (in_q.size() == 0) || (int'($urandom_range(0, 99)) < bubble_pct);
      bus.in_dout  = (in_q.size() != 0) ? in_q[0] : 8'h00;
      bus.out_full = int'($urandom_range(0, 99)) < full_pct;
      #1;
      if (bus.in_rd_en && bus.in_empty) rd_viol++;
      if (bus.out_wr_en && bus.out_full) wr_viol++;
      if (bus.in_rd_en && !bus.in_empty) void'(in_q.pop_front());
      if (bus.out_wr_en && !bus.out_full) got_q.push_back(bus.out_din);
    end
  end

  // Reference: apply the threshold rules directly to the whole frame.
  function automatic void model_frame();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic [7:0] p;
        logic [7:0] e;
        p = frame[r*W + c];
        e = 8'h00;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) e = 8'h00;
        else if (p > 8'd48) e = 8'hFF;
        else if (p > 8'd12) begin
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if ((dr != 0 || dc != 0) && frame[(r+dr)*W + c + dc] > 8'd48) e = 8'hFF;
        end
        exp_q.push_back(e);
      end
    end
  endfunction

  task automatic send_frame();
    model_frame();
    for (int i = 0; i < N; i++) in_q.push_back(frame[i]);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) frame[i] = 8'h00;
  endtask

  task automatic random_frame();
    for (int i = 0; i < N; i++)
      frame[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(40, 120)) : 8'($urandom_range(0, 30));
  endtask

  task automatic wait_outputs(input int n);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    repeat (40) @(negedge clock);
    #2;
  endtask

  function automatic logic [7:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 8'h5A;
  endfunction

  task automatic test_reset();
    in_q.push_back(8'd77);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #2;
    vectors++; if (bus.in_rd_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", bus.in_rd_en); end
    vectors++; if (bus.out_wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", bus.out_wr_en); end
    vectors++; if (bus.out_din !== 8'h00) begin miscompares++; $display("FAIL reset_din: got %h want 00", bus.out_din); end
    vectors++; if (dut.state_q !== FILL) begin miscompares++; $display("FAIL reset_state: got %0d want FILL", dut.state_q); end
    in_q.delete();
    @(negedge clock);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_zero_frame();
    got_q.delete(); exp_q.delete();
    clear_frame();
    send_frame();
    wait_outputs(N);
    vectors++; if (got_q.size() !== N) begin miscompares++; $display("FAIL zero_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (got_at(i) !== 8'h00) begin miscompares++; $display("FAIL zero_px[%0d]: got %h want 00", i, got_at(i)); end
    end
    vectors++; if (dut.state_q !== FILL) begin miscompares++; $display("FAIL zero_state: got %0d want FILL", dut.state_q); end
  endtask

  task automatic test_single_strong();
    got_q.delete(); exp_q.delete();
    clear_frame();
    frame[19] = 8'd200;
    send_frame();
    wait_outputs(N);
    vectors++; if (got_q.size() !== N) begin miscompares++; $display("FAIL single_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (got_at(i) !== exp_q[i]) begin miscompares++; $display("FAIL single_px[%0d]: got %h want %h", i, got_at(i), exp_q[i]); end
    end
    vectors++; if (got_at(19) !== 8'hFF) begin miscompares++; $display("FAIL single_19: got %h want ff", got_at(19)); end
  endtask

  task automatic test_weak_strong();
    got_q.delete(); exp_q.delete();
    clear_frame();
    frame[19] = 8'd20;
    frame[28] = 8'd100;
    frame[34] = 8'd20;
    send_frame();
    wait_outputs(N);
    vectors++; if (got_q.size() !== N) begin miscompares++; $display("FAIL weak_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (got_at(i) !== exp_q[i]) begin miscompares++; $display("FAIL weak_px[%0d]: got %h want %h", i, got_at(i), exp_q[i]); end
    end
    vectors++; if (got_at(19) !== 8'hFF) begin miscompares++; $display("FAIL weak_19: got %h want ff", got_at(19)); end
    vectors++; if (got_at(28) !== 8'hFF) begin miscompares++; $display("FAIL weak_28: got %h want ff", got_at(28)); end
    vectors++; if (got_at(34) !== 8'h00) begin miscompares++; $display("FAIL weak_34: got %h want 00", got_at(34)); end
  endtask

  task automatic test_thresholds();
    got_q.delete(); exp_q.delete();
    clear_frame();
    frame[9]  = 8'd48;
    frame[21] = 8'd12;
    frame[30] = 8'd49;
    frame[5]  = 8'd255;
    frame[31] = 8'd255;
    send_frame();
    wait_outputs(N);
    vectors++; if (got_q.size() !== N) begin miscompares++; $display("FAIL thr_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (got_at(i) !== exp_q[i]) begin miscompares++; $display("FAIL thr_px[%0d]: got %h want %h", i, got_at(i), exp_q[i]); end
    end
    vectors++; if (got_at(9)  !== 8'h00) begin miscompares++; $display("FAIL thr_eq_high: got %h want 00", got_at(9)); end
    vectors++; if (got_at(21) !== 8'h00) begin miscompares++; $display("FAIL thr_eq_low: got %h want 00", got_at(21)); end
    vectors++; if (got_at(30) !== 8'hFF) begin miscompares++; $display("FAIL thr_above_high: got %h want ff", got_at(30)); end
    vectors++; if (got_at(5)  !== 8'h00) begin miscompares++; $display("FAIL thr_top_border: got %h want 00", got_at(5)); end
    vectors++; if (got_at(31) !== 8'h00) begin miscompares++; $display("FAIL thr_right_border: got %h want 00", got_at(31)); end
  endtask

  task automatic test_stalls();
    got_q.delete(); exp_q.delete();
    random_frame();
    send_frame();
    wait_outputs(N);
    for (int i = 0; i < N; i++) begin
      vectors++; if (got_at(i) !== exp_q[i]) begin miscompares++; $display("FAIL clean_px[%0d]: got %h want %h", i, got_at(i), exp_q[i]); end
    end
    clean_q = got_q;
    got_q.delete(); exp_q.delete();
    bubble_pct = 30; full_pct = 50; rd_viol = 0; wr_viol = 0;
    send_frame();
    wait_outputs(N);
    bubble_pct = 0; full_pct = 0;
    vectors++; if (got_q.size() !== N) begin miscompares++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (got_at(i) !== clean_q[i]) begin miscompares++; $display("FAIL stall_px[%0d]: got %h want %h", i, got_at(i), clean_q[i]); end
    end
    vectors++; if (rd_viol !== 0) begin miscompares++; $display("FAIL pop_while_empty: got %0d want 0", rd_viol); end
    vectors++; if (wr_viol !== 0) begin miscompares++; $display("FAIL push_while_full: got %0d want 0", wr_viol); end
  endtask

  task automatic test_back_to_back();
    got_q.delete(); exp_q.delete();
    bubble_pct = 10; full_pct = 20;
    random_frame();
    send_frame();
    random_frame();
    send_frame();
    wait_outputs(2*N);
    bubble_pct = 0; full_pct = 0;
    vectors++; if (got_q.size() !== 2*N) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), 2*N); end
    for (int i = 0; i < 2*N; i++) begin
      vectors++; if (got_at(i) !== exp_q[i]) begin miscompares++; $display("FAIL b2b_px[%0d]: got %h want %h", i, got_at(i), exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    random_frame();
    for (int i = 0; i < 20; i++) in_q.push_back(frame[i]);
    guard = 0;
    while (in_q.size() != 0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    in_q.delete(); got_q.delete(); exp_q.delete();
    random_frame();
    send_frame();
    wait_outputs(N);
    vectors++; if (got_q.size() !== N) begin miscompares++; $display("FAIL rst_mid_count: got %0d want %0d", got_q.size(), N); end
    for (int i = 0; i < N; i++) begin
      vectors++; if (got_at(i) !== exp_q[i]) begin miscompares++; $display("FAIL rst_mid_px[%0d]: got %h want %h", i, got_at(i), exp_q[i]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_zero_frame();
    test_single_strong();
    test_weak_strong();
    test_thresholds();
    test_stalls();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
